// File: rtl/tof_udp_length_deframer_pkg.sv
// Shared types and constants for the length-prefixed UDP deframer.
package tof_udp_length_deframer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int DEF_MAX_LENGTH_BITS = 11;
  localparam int MIN_LENGTH_BYTES    = 4;
  localparam int DATA_W              = 16;
  localparam int SKID_W              = DATA_W + 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/tof_axis_skid_buffer.sv
// Registered two-entry skid buffer; input ready depends only on local state.
module tof_axis_skid_buffer
  import tof_udp_length_deframer_pkg::*;
#(
  parameter int WIDTH = SKID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             s_fire, out_free;

  assign s_ready  = !skid_valid_q;
  assign s_fire   = s_valid && s_ready;
  assign out_free = !m_valid_q || m_ready;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (s_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/tof_udp_length_deframer.sv
// Strips a byte-length header word and regenerates tlast from it, counting malformed packets.
module tof_udp_length_deframer
  import tof_udp_length_deframer_pkg::*;
#(
  parameter int MAX_LENGTH_BITS = DEF_MAX_LENGTH_BITS
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_areset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic [7:0]          err_length_count,
  output logic [7:0]          err_framing_count
);

  // One extra bit so the full 2^MAX_LENGTH_BITS word count is representable.
  localparam int          REM_W     = MAX_LENGTH_BITS + 1;
  localparam logic [31:0] MAX_BYTES = 32'(2) << MAX_LENGTH_BITS;

  state_e           state_q, state_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [7:0]       err_len_q, err_len_d;
  logic [7:0]       err_frm_q, err_frm_d;

  logic              in_fire, len_legal, last_word, out_last;
  logic              len_evt, frm_evt;
  logic              skid_in_valid, skid_in_ready;
  logic [SKID_W-1:0] skid_in_data, skid_out_data;
  logic [31:0]       hdr_len;

  assign hdr_len   = 32'(s_axis_tdata);
  assign len_legal = !s_axis_tdata[0] && (hdr_len >= 32'(MIN_LENGTH_BYTES)) &&
                     (hdr_len <= MAX_BYTES);
  assign last_word = (remaining_q == REM_W'(1));
  assign out_last  = last_word || s_axis_tlast;

  assign s_axis_tready = !s_axis_areset && ((state_q == ST_PASS) ? skid_in_ready : 1'b1);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign skid_in_valid = s_axis_tvalid && !s_axis_areset && (state_q == ST_PASS);
  assign skid_in_data  = {first_q, out_last, s_axis_tdata};

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    len_evt     = 1'b0;
    frm_evt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (s_axis_tuser) begin
            if (!len_legal) begin
              len_evt = 1'b1;
              if (!s_axis_tlast) state_d = ST_DROP;
            end else if (s_axis_tlast) begin
              frm_evt = 1'b1;
            end else begin
              remaining_d = REM_W'(s_axis_tdata[DATA_W-1:1]);
              first_d     = 1'b1;
              state_d     = ST_PASS;
            end
          end else begin
            frm_evt = 1'b1;
          end
        end
      end
      ST_PASS: begin
        // Input tuser is ignored here: once a header is taken we never resync mid-packet.
        if (in_fire) begin
          remaining_d = remaining_q - REM_W'(1);
          first_d     = 1'b0;
          if (last_word) begin
            if (s_axis_tlast) begin
              state_d = ST_IDLE;
            end else begin
              frm_evt = 1'b1;
              state_d = ST_DROP;
            end
          end else if (s_axis_tlast) begin
            frm_evt = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (in_fire && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_len_d = sat_inc8(err_len_q, len_evt);
    err_frm_d = sat_inc8(err_frm_q, frm_evt);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      err_len_q   <= '0;
      err_frm_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      err_len_q   <= err_len_d;
      err_frm_q   <= err_frm_d;
    end
  end

  tof_axis_skid_buffer #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk     (s_axis_aclk),
    .rst     (s_axis_areset),
    .s_valid (skid_in_valid),
    .s_ready (skid_in_ready),
    .s_data  (skid_in_data),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (skid_out_data)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skid_out_data;
  assign err_length_count  = err_len_q;
  assign err_framing_count = err_frm_q;

endmodule

// File: tb/tb_tof_udp_length_deframer.sv
// Scoreboard bench for the length deframer: packet model pushes expected beats, monitor pops.
module tb_tof_udp_length_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_user = 1'b0;
  logic        s_last = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_user;
  logic        m_last;
  logic [7:0]  err_len;
  logic [7:0]  err_frm;

  typedef struct {
    logic [17:0] w;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          tog_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [17:0] stall_beat = '0;
  logic [7:0]  exp_len = '0;
  logic [7:0]  exp_frm = '0;

  tof_udp_length_deframer #(.MAX_LENGTH_BITS(11)) dut (
    .s_axis_aclk       (clk),
    .s_axis_areset     (rst),
    .s_axis_tdata      (s_data),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tuser      (s_user),
    .s_axis_tlast      (s_last),
    .m_axis_tdata      (m_data),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tuser      (m_user),
    .m_axis_tlast      (m_last),
    .err_length_count  (err_len),
    .err_framing_count (err_frm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tog_en) m_ready = ~m_ready;
    else        m_ready = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Output monitor: samples on the falling edge, a beat counts when valid&&ready.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_beat", 32'({m_user, m_last, m_data}), 32'(stall_beat));
      end
      stall_prev = m_valid && !m_ready;
      stall_beat = {m_user, m_last, m_data};
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'({m_user, m_last, m_data}), 32'h3FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_beat", 32'({m_user, m_last, m_data}), 32'(e.w));
          if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
    end
  end

  task automatic drive(input logic u, input logic l, input logic [15:0] d,
                       input bit fwd, input logic [17:0] ew, input bit lat);
    s_user  = u;
    s_last  = l;
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) begin
        if (fwd) begin
          exp_t e;
          e.w   = ew;
          e.cyc = cyc;
          e.lat = lat;
          sb.push_back(e);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("drive_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_and_check(input string tag);
    s_valid = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_err_len"}, 32'(err_len), 32'(exp_len));
    chk({tag, "_err_frm"}, 32'(err_frm), 32'(exp_frm));
  endtask

  // Reference packet model: forward min(n, hdr/2) words of a legal packet, tlast on the last one.
  task automatic send_pkt(input string tag, input logic [15:0] hdr, input int n,
                          input logic [15:0] base, input bit lat, input bit mid_user);
    bit          legal;
    int          words;
    logic [15:0] d;
    legal = !hdr[0] && (hdr >= 16'd4) && (hdr <= 16'd4096);
    words = int'(hdr) / 2;
    drive(1'b1, (n == 0), hdr, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = base + 16'(i);
      drive((i == 1) && mid_user, (i == n - 1), d, legal && (i < words),
            {(i == 0), (i == words - 1) || (i == n - 1), d}, lat);
    end
    if (!legal)          exp_len = sat8(exp_len);
    else if (n != words) exp_frm = sat8(exp_frm);
    drain_and_check(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_beat", 32'({m_user, m_last, m_data}), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_err_frm", 32'(err_frm), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send_pkt("basic", 16'h0008, 4, 16'h000A, 1'b1, 1'b0);
    tog_en = 1'b1;
    send_pkt("toggle", 16'h0008, 4, 16'h000A, 1'b0, 1'b0);
    send_pkt("toggle_long", 16'h0020, 16, 16'h1100, 1'b0, 1'b0);
    tog_en = 1'b0;
    @(posedge clk); #1;
    send_pkt("odd_len", 16'h0007, 3, 16'h2200, 1'b0, 1'b0);
    send_pkt("after_odd", 16'h0006, 3, 16'h3300, 1'b1, 1'b1);
    send_pkt("long_pkt", 16'h0008, 6, 16'h4400, 1'b0, 1'b0);
    send_pkt("short_pkt", 16'h0008, 2, 16'h5500, 1'b0, 1'b0);
    send_pkt("after_short", 16'h0004, 2, 16'h5A00, 1'b1, 1'b0);
    send_pkt("oversize", 16'd4098, 2, 16'h6600, 1'b0, 1'b0);
    send_pkt("too_small_hdr_only", 16'h0002, 0, 16'h0000, 1'b0, 1'b0);
    send_pkt("legal_hdr_only", 16'h0008, 0, 16'h0000, 1'b0, 1'b0);
    send_pkt("max_len", 16'd4096, 2048, 16'h8000, 1'b1, 1'b0);

    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 1'b0, 16'(i), 1'b0, '0, 1'b0);
      exp_frm = sat8(exp_frm);
    end
    drain_and_check("frm_saturate");
    chk("frm_sat_value", 32'(err_frm), 32'd255);

    drive(1'b1, 1'b0, 16'h0008, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 16'h9000, 1'b1, {1'b1, 1'b0, 16'h9000}, 1'b0);
    drive(1'b0, 1'b0, 16'h9001, 1'b1, {1'b0, 1'b0, 16'h9001}, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_err_len", 32'(err_len), 32'd0);
    chk("midrst_err_frm", 32'(err_frm), 32'd0);
    sb.delete();
    exp_len = '0;
    exp_frm = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    send_pkt("after_rst", 16'h0008, 4, 16'h000A, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tof_udp_length_deframer.md
TOF_UDP_LENGTH_DEFRAMER -- requirements
Module: tof_udp_length_deframer

Interface
REQ-001 Parameter MAX_LENGTH_BITS, default 11: width of the word counter; max payload 2^MAX_LENGTH_BITS words (4096 bytes).
REQ-002 s_axis_aclk  input  1  single clock; all logic on rising edge.
REQ-003 s_axis_areset  input  1  synchronous, active-high reset.
REQ-004 s_axis_tdata  input  16  length-prefixed stream; header word = payload length in bytes.
REQ-005 s_axis_tvalid / s_axis_tready  input / output  1 each  AXI4-Stream handshake.
REQ-006 s_axis_tuser  input  1  marks header word.
REQ-007 s_axis_tlast  input  1  marks last payload word.
REQ-008 m_axis_tdata  output  16  payload word, HELIX framing.
REQ-009 m_axis_tvalid / m_axis_tready  output / input  1 each  AXI4-Stream handshake.
REQ-010 m_axis_tuser  output  1  first payload word of packet.
REQ-011 m_axis_tlast  output  1  last payload word, generated from header length.
REQ-012 err_length_count  output  8  saturating count of packets with illegal header length.
REQ-013 err_framing_count  output  8  saturating count of tlast/length mismatches and stray words.

Function
REQ-014 States SHALL be IDLE, PASS, DROP; reset state IDLE.
REQ-015 IDLE: s_axis_tready SHALL be 1; no word accepted in IDLE reaches m_axis.
REQ-016 IDLE, accepted word with tuser=1, tlast=0, length even, 4..2*2^MAX_LENGTH_BITS bytes: load remaining = length/2, set first flag, go PASS.
REQ-017 IDLE, tuser=1 with odd, <4 or oversize length: err_length_count +1; go DROP if tlast=0, else stay IDLE.
REQ-018 IDLE, tuser=1 with tlast=1 (header-only) and legal length: err_framing_count +1, stay IDLE.
REQ-019 IDLE, tuser=0 word: discarded, err_framing_count +1, stay IDLE.
REQ-020 PASS: s_axis_tready SHALL equal output stage ready; each accepted word forwarded with m_axis_tuser=first flag, m_axis_tlast=(remaining==1); remaining decrements, first flag clears.
REQ-021 PASS, remaining==1 and input tlast=1: return IDLE.
REQ-022 PASS, remaining==1 and input tlast=0 (long packet): output tlast=1, err_framing_count +1, go DROP.
REQ-023 PASS, input tlast=1 with remaining>1 (short packet): output word with tlast=1 (truncated), err_framing_count +1, go IDLE.
REQ-024 PASS, input tuser=1: treated as data; no resync mid-packet.
REQ-025 DROP: s_axis_tready=1, words discarded; accepted tlast returns IDLE.
REQ-026 Latency: accepted payload word SHALL appear on m_axis on the next cycle; full throughput one word/cycle with m_axis_tready=1.
REQ-027 Output stage SHALL be a registered skid buffer: m_axis_* stable while tvalid=1 and tready=0; no combinational path m_axis_tready -> s_axis_tready.
REQ-028 Error counters SHALL saturate at 255, never wrap; simultaneous events counted once per packet event.

Reset
REQ-029 Reset: state IDLE, remaining=0, first flag=0, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, both error counters=0.
REQ-030 Reset mid-packet SHALL discard skid buffer contents; next packet begins with a header.
REQ-031 s_axis_tready SHALL be 0 during reset assertion.

Structure
REQ-032 Shared package: state encoding, MAX_LENGTH_BITS default, minimum length constant (4 bytes).
REQ-033 One sub-module: tof_axis_skid_buffer (18-bit payload: tuser, tlast, tdata).

Verification
REQ-034 Header 0x0008 then 4 words A,B,C,D (tlast on D), m_ready=1 -> m_axis A(tuser=1),B,C,D(tlast=1), one cycle after each input, no errors.
REQ-035 Same packet, m_axis_tready toggled 1/0 each cycle -> identical output sequence, no loss or duplication, data stable while stalled.
REQ-036 Header 0x0007 + 3 words -> no output, err_length_count=1; following legal packet passes intact.
REQ-037 Header 0x0008 + 6 words (tlast on 6th) -> 4 words out, tlast on 4th, err_framing_count=1; words 5-6 dropped.
REQ-038 Header 0x0008 + 2 words (tlast on 2nd) -> 2 words out, tlast on 2nd, err_framing_count=1, back in IDLE.
REQ-039 Reset asserted after 2nd payload word -> m_axis_tvalid=0 next cycle, counters 0; subsequent packet correct.
